// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt priority sequencer.
package irq_seq_pkg;

  localparam int NUM_SRC = 16;
  localparam int PRIO_W  = 4;
  localparam int VEC_W   = 8;
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam logic [VEC_W-1:0] VEC_BASE = 8'd64;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CPU_REQ,
    CPU_SVC,
    DTC_REQ
  } state_e;

  function automatic logic [PRIO_W-1:0] ipr_of(input logic [NUM_SRC*PRIO_W-1:0] ipr, input int idx);
    return ipr[idx*PRIO_W +: PRIO_W];
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational max-priority select over eligible sources; zero latency, no backpressure.
// IRQ_SEQ_RR_EN: equal-priority ties rotate from rr_ptr_i instead of lowest index.
module irq_prio_arb
  import irq_seq_pkg::*;
(
  input  logic [NUM_SRC-1:0]        elig_i,
  input  logic [NUM_SRC*PRIO_W-1:0] ipr_i,
`ifdef IRQ_SEQ_RR_EN
  input  logic [SRC_W-1:0]          rr_ptr_i,
`endif
  output logic [SRC_W-1:0]          win_idx_o,
  output logic [PRIO_W-1:0]         win_lvl_o,
  output logic                      any_vld_o
);

  logic [PRIO_W-1:0] max_lvl;

  always_comb begin
    max_lvl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig_i[i] && (ipr_of(ipr_i, i) > max_lvl)) max_lvl = ipr_of(ipr_i, i);
    end
  end

`ifdef IRQ_SEQ_RR_EN
  always_comb begin
    logic found;
    logic [SRC_W-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    win_idx_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr_i + SRC_W'(k);
      if (!found && elig_i[idx] && (ipr_of(ipr_i, int'(idx)) == max_lvl)) begin
        win_idx_o = idx;
        found     = 1'b1;
      end
    end
  end
`else
  // Descending scan so the lowest matching index is written last.
  always_comb begin
    win_idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig_i[i] && (ipr_of(ipr_i, i) == max_lvl)) win_idx_o = SRC_W'(i);
    end
  end
`endif

  assign win_lvl_o = max_lvl;
  assign any_vld_o = |elig_i;

endmodule

// File: rtl/irq_priority_sequencer.sv
// Hands the best eligible IRQ to CPU or DTC; request visible 2 cycles after eligibility, held until ack.
// Optional IRQ_SEQ_RR_EN adds a round-robin tie pointer advanced on each grant.
module irq_priority_sequencer
  import irq_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        irq_req,
  input  logic [NUM_SRC*PRIO_W-1:0] ipr,
  input  logic [PRIO_W-1:0]         cpu_mask,
  input  logic [NUM_SRC-1:0]        dtcer,
  output logic                      int_req,
  output logic [VEC_W-1:0]          int_vec,
  output logic [PRIO_W-1:0]         int_level,
  input  logic                      int_ack,
  input  logic                      int_done,
  output logic                      dtc_req,
  output logic [SRC_W-1:0]          dtc_src,
  input  logic                      dtc_ack,
  output logic [NUM_SRC-1:0]        clr_src,
  output logic                      exc_handling,
  output logic                      busy
);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   win_q, win_d;
  logic [PRIO_W-1:0]  lvl_q, lvl_d;
  logic [NUM_SRC-1:0] cool_q;
  logic [NUM_SRC-1:0] elig;
  logic [SRC_W-1:0]   arb_win;
  logic [PRIO_W-1:0]  arb_lvl;
  logic               arb_vld;
  logic               grant;
  logic               withdraw;

  logic               int_req_q, int_req_d;
  logic [VEC_W-1:0]   int_vec_q, int_vec_d;
  logic [PRIO_W-1:0]  int_lvl_q, int_lvl_d;
  logic               dtc_req_q, dtc_req_d;
  logic [SRC_W-1:0]   dtc_src_q, dtc_src_d;
  logic [NUM_SRC-1:0] clr_src_q, clr_src_d;
  logic               exc_q, exc_d;
  logic               busy_q, busy_d;

  // A cleared source stays blocked in its clear cycle and the one after, while the flag unit catches up.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = irq_req[i] && (ipr_of(ipr, i) > cpu_mask) && !clr_src_q[i] && !cool_q[i];
    end
  end

  assign withdraw = !irq_req[win_q] || (ipr_of(ipr, int'(win_q)) <= cpu_mask);
  assign grant    = ((state_q == CPU_REQ) && int_ack) || ((state_q == DTC_REQ) && dtc_ack);

`ifdef IRQ_SEQ_RR_EN
  logic [SRC_W-1:0] rr_q;

  always_ff @(posedge clk) begin
    if (rst)        rr_q <= '0;
    else if (grant) rr_q <= win_q + SRC_W'(1);
  end
`endif

  irq_prio_arb u_arb (
    .elig_i    (elig),
    .ipr_i     (ipr),
`ifdef IRQ_SEQ_RR_EN
    .rr_ptr_i  (rr_q),
`endif
    .win_idx_o (arb_win),
    .win_lvl_o (arb_lvl),
    .any_vld_o (arb_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      lvl_q     <= '0;
      cool_q    <= '0;
      int_req_q <= 1'b0;
      int_vec_q <= '0;
      int_lvl_q <= '0;
      dtc_req_q <= 1'b0;
      dtc_src_q <= '0;
      clr_src_q <= '0;
      exc_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      lvl_q     <= lvl_d;
      cool_q    <= clr_src_q;
      int_req_q <= int_req_d;
      int_vec_q <= int_vec_d;
      int_lvl_q <= int_lvl_d;
      dtc_req_q <= dtc_req_d;
      dtc_src_q <= dtc_src_d;
      clr_src_q <= clr_src_d;
      exc_q     <= exc_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE:    if (|elig) state_d = ARB;
      ARB: begin
        if (arb_vld) begin
          win_d   = arb_win;
          lvl_d   = arb_lvl;
          state_d = dtcer[arb_win] ? DTC_REQ : CPU_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_REQ: begin
        if (int_ack)       state_d = CPU_SVC;
        else if (withdraw) state_d = IDLE;
      end
      CPU_SVC: if (int_done) state_d = IDLE;
      DTC_REQ: if (dtc_ack)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req_d = (state_d == CPU_REQ);
    int_vec_d = '0;
    int_lvl_d = '0;
    if (int_req_d) begin
      int_vec_d = VEC_BASE + VEC_W'(win_d);
      int_lvl_d = lvl_d;
    end
    dtc_req_d = (state_d == DTC_REQ);
    dtc_src_d = dtc_req_d ? win_d : '0;
    exc_d     = (state_d == CPU_SVC);
    busy_d    = (state_d != IDLE);
    clr_src_d = '0;
    if (grant) clr_src_d[win_q] = 1'b1;
  end

  assign int_req      = int_req_q;
  assign int_vec      = int_vec_q;
  assign int_level    = int_lvl_q;
  assign dtc_req      = dtc_req_q;
  assign dtc_src      = dtc_src_q;
  assign clr_src      = clr_src_q;
  assign exc_handling = exc_q;
  assign busy         = busy_q;

endmodule
